// File: rtl/conv_window_scanner_pkg.sv
// Shared widths, FSM states and the shift/saturate helper
// for the streaming KxK convolution window scanner.
package conv_window_scanner_pkg;
  localparam int DATA_W    = 16;
  localparam int MAX_IMG   = 32;
  localparam int MAX_K     = 5;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;
  localparam int TAPS      = MAX_K * MAX_K;
  localparam int ADDR_W    = $clog2(MAX_IMG * MAX_IMG);
  localparam int IDX_W     = $clog2(MAX_IMG + 1);
  localparam int KW        = $clog2(MAX_K + 1);
  localparam int TW        = $clog2(TAPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - 1;

  function automatic logic signed [DATA_W-1:0] sat_shift(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_BITS;
    if (sh > SAT_HI) sh = SAT_HI;
    else if (sh < SAT_LO) sh = SAT_LO;
    return sh[DATA_W-1:0];
  endfunction
endpackage

// File: rtl/conv_window_scanner_if.sv
// RAM read port and result stream of the window scanner.
// master = scanner side, slave = RAM / consumer side.
interface conv_window_scanner_if;
  import conv_window_scanner_pkg::*;

  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] out_data;
  logic [7:0]               out_row;
  logic [7:0]               out_col;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output rd_en, rd_addr,
    output out_data, out_row, out_col, out_valid,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    input  out_data, out_row, out_col, out_valid,
    output rd_data, out_ready
  );
endinterface

// File: rtl/conv_window_scanner_mac_window.sv
// Registered dot product of window and filter over the
// first `taps` entries, shifted and saturated to DATA_W.
module conv_window_scanner_mac_window
  import conv_window_scanner_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [TW-1:0]                taps,
  input  logic [TAPS-1:0][DATA_W-1:0]  win,
  input  logic [TAPS-1:0][DATA_W-1:0]  coef,
  output logic signed [DATA_W-1:0]     res
);
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  a;
  logic signed [ACC_W-1:0]  b;
  logic signed [DATA_W-1:0] res_d;
  logic signed [DATA_W-1:0] res_q;

  always_comb begin
    acc = '0;
    a   = '0;
    b   = '0;
    for (int i = 0; i < TAPS; i++) begin
      a = ACC_W'($signed(win[i]));
      b = ACC_W'($signed(coef[i]));
      if (i < int'(taps)) acc = acc + a * b;
    end
    res_d = en ? sat_shift(acc) : res_q;
  end

  always_ff @(posedge clk) begin
    if (reset) res_q <= '0;
    else       res_q <= res_d;
  end

  assign res = res_q;
endmodule

// File: rtl/conv_window_scanner.sv
// Scans KxK windows out of an image RAM, one MAC per
// window, results handed off on a valid/ready stream.
module conv_window_scanner
  import conv_window_scanner_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [15:0]                 img_size,
  input  logic [15:0]                 filter_size,
  input  logic [1:0]                  stride,
  input  logic [TAPS-1:0][DATA_W-1:0] filter,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  conv_window_scanner_if.master       bus
);
  state_t state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d, lim_q, lim_d;
  logic [IDX_W-1:0] r_q, r_d, c_q, c_d;
  logic [KW-1:0]    k_q, k_d, x_q, x_d, y_q, y_d;
  logic [1:0]       s_q, s_d;
  logic [TW-1:0]    kk_q, kk_d, tap_q, tap_d;
  logic [TW-1:0]    cap_idx_q, cap_idx_d;
  logic             cap_v_q, cap_v_d;
  logic [7:0]       orow_q, orow_d, ocol_q, ocol_d;
  logic [TAPS-1:0][DATA_W-1:0] win_q, win_d;
  logic [TAPS-1:0][DATA_W-1:0] filt_q, filt_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic legal, begin_win, mac_en;
  logic [IDX_W-1:0] cn, rn;
  logic signed [DATA_W-1:0] mac_res;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [IDX_W-1:0] r, c, n,
    input logic [KW-1:0]    x, y
  );
    logic [2*IDX_W:0] a;
    a = ((2*IDX_W+1)'(r) + (2*IDX_W+1)'(x)) * (2*IDX_W+1)'(n)
      + (2*IDX_W+1)'(c) + (2*IDX_W+1)'(y);
    return a[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    lim_d       = lim_q;
    r_d         = r_q;
    c_d         = c_q;
    k_d         = k_q;
    x_d         = x_q;
    y_d         = y_q;
    s_d         = s_q;
    kk_d        = kk_q;
    tap_d       = tap_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    win_d       = win_q;
    filt_d      = filt_q;
    rd_en_d     = rd_en_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cap_v_d     = rd_en_q;
    cap_idx_d   = tap_q;
    begin_win   = 1'b0;
    mac_en      = 1'b0;
    cn = c_q + IDX_W'(s_q);
    rn = r_q + IDX_W'(s_q);
    legal = (filter_size == 16'd1 || filter_size == 16'd3 ||
             filter_size == 16'd5)
         && filter_size <= 16'(MAX_K)
         && filter_size <= img_size
         && img_size <= 16'(MAX_IMG)
         && (stride == 2'd1 || stride == 2'd2);

    unique case (state_q)
      S_IDLE: begin
        if (start && legal) begin
          n_d    = img_size[IDX_W-1:0];
          k_d    = filter_size[KW-1:0];
          kk_d   = TW'(filter_size[KW-1:0]) * TW'(filter_size[KW-1:0]);
          lim_d  = img_size[IDX_W-1:0] - IDX_W'(filter_size[KW-1:0]);
          s_d    = stride;
          filt_d = filter;
          r_d    = '0;
          c_d    = '0;
          orow_d = '0;
          ocol_d = '0;
          busy_d = 1'b1;
          begin_win = 1'b1;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (rd_en_q) begin
          if (tap_q == kk_q - TW'(1)) begin
            rd_en_d = 1'b0;
          end else begin
            tap_d = tap_q + TW'(1);
            if (y_q == k_q - KW'(1)) begin
              y_d = '0;
              x_d = x_q + KW'(1);
            end else begin
              y_d = y_q + KW'(1);
            end
          end
        end
        if (cap_v_q) begin
          win_d[cap_idx_q] = bus.rd_data;
          if (cap_idx_q == kk_q - TW'(1)) state_d = S_MAC;
        end
      end
      S_MAC: begin
        mac_en      = 1'b1;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (cn <= lim_q) begin
            c_d    = cn;
            ocol_d = ocol_q + 8'd1;
            begin_win = 1'b1;
          end else if (rn <= lim_q) begin
            c_d    = '0;
            r_d    = rn;
            ocol_d = '0;
            orow_d = orow_q + 8'd1;
            begin_win = 1'b1;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (begin_win) begin
      x_d     = '0;
      y_d     = '0;
      tap_d   = '0;
      rd_en_d = 1'b1;
      state_d = S_LOAD;
    end
    rd_addr_d = rd_en_d ? addr_of(r_d, c_d, n_d, x_d, y_d)
                        : rd_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      lim_q       <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      s_q         <= '0;
      kk_q        <= '0;
      tap_q       <= '0;
      cap_idx_q   <= '0;
      cap_v_q     <= 1'b0;
      orow_q      <= '0;
      ocol_q      <= '0;
      win_q       <= '0;
      filt_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      lim_q       <= lim_d;
      r_q         <= r_d;
      c_q         <= c_d;
      k_q         <= k_d;
      x_q         <= x_d;
      y_q         <= y_d;
      s_q         <= s_d;
      kk_q        <= kk_d;
      tap_q       <= tap_d;
      cap_idx_q   <= cap_idx_d;
      cap_v_q     <= cap_v_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      win_q       <= win_d;
      filt_q      <= filt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  conv_window_scanner_mac_window u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (mac_en),
    .taps  (kk_q),
    .win   (win_q),
    .coef  (filt_q),
    .res   (mac_res)
  );

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_data  = mac_res;
  assign bus.out_row   = orow_q;
  assign bus.out_col   = ocol_q;
  assign bus.out_valid = out_valid_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_conv_window_scanner.sv
// Scoreboard bench for conv_window_scanner: a behavioural
// model queues expected results, a monitor pops on handshake.
module tb_conv_window_scanner;
  import conv_window_scanner_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [15:0] img_size = '0;
  logic [15:0] filter_size = '0;
  logic [1:0]  stride = '0;
  logic [TAPS-1:0][DATA_W-1:0] filter = '0;
  logic busy, done, err;

  conv_window_scanner_if bus();

  conv_window_scanner dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .img_size    (img_size),
    .filter_size (filter_size),
    .stride      (stride),
    .filter      (filter),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  logic signed [15:0] mem [1024];
  always @(posedge clk)
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  typedef struct { int d; int r; int c; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int out_cnt = 0;
  bit hold_low = 1'b0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done) begin
        done_cnt++;
        check("busy_with_done", int'(busy), 0);
      end
      if (bus.out_valid) check("rd_while_out", int'(bus.rd_en), 0);
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0d required=none",
                   int'(bus.out_data));
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(bus.out_data), e.d);
          check("out_row", int'(bus.out_row), e.r);
          check("out_col", int'(bus.out_col), e.c);
        end
      end
    end
  end

  task automatic model(int n, int k, int s);
    longint acc;
    int side;
    side = (n - k) / s + 1;
    for (int r = 0; r < side; r++)
      for (int c = 0; c < side; c++) begin
        acc = 0;
        for (int x = 0; x < k; x++)
          for (int y = 0; y < k; y++)
            acc += longint'(mem[(r*s + x)*n + c*s + y])
                 * longint'($signed(filter[x*k + y]));
        acc = acc >>> FRAC_BITS;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        exp_q.push_back('{int'(acc), r, c});
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_scan(int n, int k, int s);
    img_size = 16'(n);
    filter_size = 16'(k);
    stride = 2'(s);
    pulse_start();
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(int base, string tag);
    int cyc = 0;
    while (done_cnt == base && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, done_cnt - base, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic load_ramp_t1();
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    for (int i = 0; i < TAPS; i++) filter[i] = 16'd256;
    exp_q.push_back('{45, 0, 0});
    exp_q.push_back('{54, 0, 1});
    exp_q.push_back('{81, 1, 0});
    exp_q.push_back('{90, 1, 1});
  endtask

  task automatic randomize_data(int n, int lo, int hi);
    for (int i = 0; i < n*n; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < TAPS; i++)
      filter[i] = 16'(int'($urandom_range(0, hi - lo)) + lo);
  endtask

  task automatic err_case(int n, int k, int s, string tag);
    img_size = 16'(n);
    filter_size = 16'(k);
    stride = 2'(s);
    pulse_start();
    check({tag, "_err"}, int'(err), 1);
    check({tag, "_busy"}, int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_no_rd"}, int'(bus.rd_en | busy), 0);
    end
    check({tag, "_err_pulse"}, int'(err), 0);
  endtask

  initial begin
    int base, cyc, ob, d0, r0, c0, k, n, s;
    int ks[3] = '{1, 3, 5};
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cyc, ob, d0, r0, c0, k, n, s;
    int ks[3];
    ks = '{1, 3, 5};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", int'(bus.rd_en), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done_err", int'(done | err), 0);
    @(posedge clk); #1 reset = 1'b0;

    load_ramp_t1();
    base = done_cnt;
    start_scan(4, 3, 1);
    wait_done(base, "t1");

    for (int i = 0; i < 25; i++) mem[i] = 16'sd32767;
    for (int i = 0; i < TAPS; i++) filter[i] = 16'd256;
    exp_q.push_back('{32767, 0, 0});
    base = done_cnt;
    start_scan(5, 5, 1);
    wait_done(base, "t2_pos");
    for (int i = 0; i < 25; i++) mem[i] = -16'sd32768;
    exp_q.push_back('{-32768, 0, 0});
    base = done_cnt;
    start_scan(5, 5, 1);
    wait_done(base, "t2_neg");

    randomize_data(32, -300, 300);
    model(32, 3, 2);
    check("t3_last_row", exp_q[exp_q.size()-1].r, 14);
    base = done_cnt;
    ob = out_cnt;
    start_scan(32, 3, 2);
    wait_done(base, "t3");
    check("t3_count", out_cnt - ob, 225);

    randomize_data(6, -400, 400);
    model(6, 3, 1);
    base = done_cnt;
    start_scan(6, 3, 1);
    cyc = 0;
    while (out_cnt < ob + 225 + 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    hold_low = 1'b1;
    repeat (2) @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (!bus.out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_valid_seen", int'(bus.out_valid), 1);
    d0 = int'(bus.out_data);
    r0 = int'(bus.out_row);
    c0 = int'(bus.out_col);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_valid_held", int'(bus.out_valid), 1);
      check("t4_data_stable", int'(bus.out_data), d0);
      check("t4_pos_stable", int'(bus.out_row)*256 + int'(bus.out_col),
            r0*256 + c0);
      check("t4_no_rd", int'(bus.rd_en), 0);
    end
    hold_low = 1'b0;
    wait_done(base, "t4");

    err_case(8, 4, 1, "t5_k4");
    err_case(2, 3, 1, "t5_n2k3");
    err_case(8, 3, 3, "t5_s3");
    err_case(33, 3, 1, "t5_n33");

    load_ramp_t1();
    base = done_cnt;
    start_scan(4, 3, 1);
    cyc = 0;
    while (!bus.rd_en && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_in_load", int'(bus.rd_en), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_busy", int'(busy), 0);
    check("t6_rd_en", int'(bus.rd_en), 0);
    check("t6_out_valid", int'(bus.out_valid), 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_no_done", done_cnt - base, 0);
    load_ramp_t1();
    base = done_cnt;
    start_scan(4, 3, 1);
    wait_done(base, "t6_rerun");

    for (int it = 0; it < 4; it++) begin
      k = ks[$urandom_range(0, 2)];
      n = int'($urandom_range(k, 12));
      s = int'($urandom_range(1, 2));
      randomize_data(n, -700, 700);
      model(n, k, s);
      base = done_cnt;
      start_scan(n, k, s);
      wait_done(base, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
